score_tracker: RTL
==================

SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter DIGITS, default 4, legal range 1..8: number of BCD score digits.
REQ-002 Parameter LIVES, default 3, legal range 1..15: wrong answers allowed before game over.
REQ-003 Parameter SATURATE, default 0: 0 = score wraps to zero at overflow; 1 = score holds at all nines.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 clear  input  1  synchronous reset, active-high; full reset.
REQ-006 restart  input  1  synchronous soft restart, active-high.
REQ-007 check  input  2  per-cycle verdict code: 2'b11 correct, 2'b00 wrong, 2'b01 stay, 2'b10 reserved.
REQ-008 score  output  4*DIGITS  BCD score; nibble 0 (bits 3:0) is the least significant digit.
REQ-009 lives  output  4  remaining lives.
REQ-010 game_over  output  1  high while lives == 0.
REQ-011 overflow  output  1  sticky flag; set when the score passes all nines.
REQ-012 high_score  output  4*DIGITS  best BCD score; present only with SCORE_HIGH_EN.
REQ-013 new_high  output  1  one-cycle pulse when high_score updates; present only with SCORE_HIGH_EN.

Function
REQ-014 All outputs shall be registered; an event sampled at edge N shall be visible after edge N, with 1-cycle latency.
REQ-015 check is evaluated every cycle; a code held for K cycles shall count K events.
REQ-016 check 2'b01 and 2'b10 shall leave all state unchanged.
REQ-017 check 2'b11 with game_over low shall increment score by one in decimal, carrying a digit from 9 to 0 into the next digit.
REQ-018 Increment from all nines with SATURATE=0 shall give score 0 and set overflow.
REQ-019 Increment from all nines with SATURATE=1 shall hold score at all nines and set overflow.
REQ-020 check 2'b00 with game_over low shall decrement lives by one; score shall be unchanged.
REQ-021 game_over shall rise on the same edge that lives reaches 0.
REQ-022 While game_over is high, all check codes shall be ignored; only clear or restart leave this state.
REQ-023 States: PLAY (lives>0) -> OVER on the wrong answer that takes lives to 0.
REQ-024 States: OVER -> PLAY on clear or restart.
REQ-025 Priority: clear > restart > check; a check in the same cycle as clear or restart shall be dropped.
REQ-026 restart shall set score=0, lives=LIVES, game_over=0 and overflow=0, and shall not change high_score.
REQ-027 Score digits shall never hold a value above 9.

Reset
REQ-028 On clear: score=0, lives=LIVES, game_over=0, overflow=0, high_score=0, new_high=0.
REQ-029 clear asserted mid-operation shall take effect at the next edge, whatever the state.
REQ-030 There shall be no asynchronous reset path.

Configuration
REQ-031 Macro SCORE_HIGH_EN defined: high_score and new_high are implemented.
REQ-032 With SCORE_HIGH_EN, when score > high_score (digit-wise BCD compare), the next edge shall load high_score with score and pulse new_high for one cycle; this is a 1-cycle lag after score.
REQ-033 With SCORE_HIGH_EN, high_score shall survive restart and be cleared only by clear.
REQ-034 Macro SCORE_HIGH_EN undefined: the ports high_score and new_high are absent and no compare logic is built; all other behaviour is identical.

Verification
REQ-035 DIGITS=4: clear, then 1234 cycles of check=11 -> score=16'h1234, lives=3, overflow=0.
REQ-036 DIGITS=2, SATURATE=0: 100 correct -> score=8'h00, overflow=1; SATURATE=1, 100 correct -> score=8'h99, overflow=1.
REQ-037 LIVES=3: 3 wrong -> lives 2,1,0, game_over=1 after the 3rd edge; 5 further correct -> score unchanged.
REQ-038 restart and check=11 asserted in the same cycle at score=8'h07 -> score=0, lives=LIVES, game_over=0.
REQ-039 With SCORE_HIGH_EN: score 5 -> high_score=5 one cycle later with a single new_high pulse; restart -> score 0, high_score 5; clear -> high_score 0.
REQ-040 clear asserted during a stream of check=11 -> all outputs at reset values on the following cycle, and counting resumes the cycle after clear deasserts.

Source files
------------

// File: rtl/score_tracker.sv
// score_tracker: BCD score counter with a lives budget and game-over state.
// Optional feature: define SCORE_HIGH_EN to build the high_score / new_high
// tracking logic and expose its ports; without it those ports are absent.
module score_tracker #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned LIVES    = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  restart,
    input  logic [1:0]            check,
    output logic [4*DIGITS-1:0]   score,
    output logic [3:0]            lives,
    output logic                  game_over,
`ifdef SCORE_HIGH_EN
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  new_high
`else
    output logic                  overflow
`endif
);

    localparam int unsigned SW = 4 * DIGITS;

    localparam logic [1:0] CHK_WRONG   = 2'b00;
    localparam logic [1:0] CHK_CORRECT = 2'b11;

    typedef enum logic {
        S_PLAY = 1'b0,
        S_OVER = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   score_q;
    logic [SW-1:0]   score_d;
    logic [SW-1:0]   score_inc;
    logic            inc_carry;
    logic [3:0]      lives_q;
    logic [3:0]      lives_d;
    logic            overflow_q;
    logic            overflow_d;

    // State register; clear wins over everything else
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the last life lost enters OVER, restart leaves it
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_PLAY;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (check == CHK_WRONG && lives_q == 4'd1) begin
                        state_d = S_OVER;
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_PLAY;
            endcase
        end
    end

    // Decimal +1 with digit ripple; a carry out of the top digit means all nines
    always_comb begin
        inc_carry = 1'b1;
        score_inc = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (inc_carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end else begin
                score_inc[4*i +: 4] = score_q[4*i +: 4];
            end
        end
    end

    // Output/datapath next values; checks are ignored in OVER and during restart
    always_comb begin
        score_d    = score_q;
        lives_d    = lives_q;
        overflow_d = overflow_q;
        if (restart) begin
            score_d    = '0;
            lives_d    = 4'(LIVES);
            overflow_d = 1'b0;
        end else if (state_q == S_PLAY) begin
            if (check == CHK_CORRECT) begin
                if (inc_carry) begin
                    overflow_d = 1'b1;
                    score_d    = (SATURATE != 0) ? score_q : score_inc;
                end else begin
                    score_d    = score_inc;
                end
            end else if (check == CHK_WRONG) begin
                lives_d = lives_q - 4'd1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (clear) begin
            score_q    <= '0;
            lives_q    <= 4'(LIVES);
            overflow_q <= 1'b0;
        end else begin
            score_q    <= score_d;
            lives_q    <= lives_d;
            overflow_q <= overflow_d;
        end
    end

    assign score     = score_q;
    assign lives     = lives_q;
    assign overflow  = overflow_q;
    assign game_over = (state_q == S_OVER);

`ifdef SCORE_HIGH_EN
    logic [SW-1:0] high_q;
    logic          new_high_q;

    // Best-score tracker; valid BCD compares correctly as plain binary
    always_ff @(posedge clock) begin
        if (clear) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else if (score_q > high_q) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
        end else begin
            new_high_q <= 1'b0;
        end
    end

    assign high_score = high_q;
    assign new_high   = new_high_q;
`endif

endmodule
